// File: rtl/falling_letter_pool.sv
// falling_letter_pool: holds up to NSLOT falling letters, moves them once
// per frame, spawns from the generator and resolves keystrokes as hit/wrong.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   frame_tick       one pulse per video frame
//   gen_ch/speed/x/y letter generator outputs, sampled in SPAWN
//   key_valid/code   keystroke event
//   rd_idx -> rd_*   combinational slot read port for the renderer
//   busy             FSM not idle
//   hit/wrong/miss   registered one-cycle event pulses
//   score/misses     saturating hit and miss counters
module falling_letter_pool #(
  parameter int NSLOT        = 8,
  parameter int SPAWN_FRAMES = 30,
  parameter int X_LIMIT      = 480,
  localparam int IW  = $clog2(NSLOT),
  localparam int FCW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic [7:0]    gen_ch,
  input  logic [3:0]    gen_speed,
  input  logic [8:0]    gen_x,
  input  logic [9:0]    gen_y,
  input  logic          key_valid,
  input  logic [7:0]    key_code,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_active,
  output logic [7:0]    rd_ch,
  output logic [8:0]    rd_x,
  output logic [9:0]    rd_y,
  output logic          busy,
  output logic          hit,
  output logic          wrong,
  output logic          miss,
  output logic [15:0]   score,
  output logic [7:0]    misses
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SPAWN,
    S_SCAN,
    S_KILL
  } state_t;

  state_t state_q, state_d;

  logic [NSLOT-1:0] act_q;
  logic [7:0]       ch_q  [NSLOT];
  logic [3:0]       spd_q [NSLOT];
  logic [8:0]       x_q   [NSLOT];
  logic [9:0]       y_q   [NSLOT];

  logic [IW-1:0]  idx_q;
  logic [FCW-1:0] fc_q;
  logic           frame_pend_q;
  logic           key_pend_q;
  logic [7:0]     key_q;
  logic [7:0]     skey_q;
  logic           bfound_q;
  logic [IW-1:0]  bidx_q;
  logic [8:0]     bx_q;
  logic           hit_q, wrong_q, miss_q;
  logic [15:0]    score_q, score_d;
  logic [7:0]     misses_q, misses_d;

  logic           start_frame, start_key;
  logic           last;
  logic [9:0]     nx;
  logic           off;
  logic           better;
  logic           fc_wrap;
  logic           free_found;
  logic [IW-1:0]  free_idx;
  logic           inc_score, inc_miss;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_pend_q)    state_d = S_MOVE;
        else if (key_pend_q) state_d = S_SCAN;
      end
      S_MOVE:  if (last) state_d = S_SPAWN;
      S_SPAWN: state_d = S_IDLE;
      S_SCAN:  if (last) state_d = S_KILL;
      S_KILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs and per-state decodes
  always_comb begin
    busy        = (state_q != S_IDLE);
    start_frame = (state_q == S_IDLE) && frame_pend_q;
    start_key   = (state_q == S_IDLE) && !frame_pend_q
                  && key_pend_q;
    inc_score   = (state_q == S_KILL) && bfound_q;
    inc_miss    = (state_q == S_MOVE) && act_q[idx_q] && off;
  end

  assign last = (idx_q == IW'(NSLOT - 1));

  // 10-bit sum so a letter near the bottom cannot wrap back to the top
  assign nx  = {1'b0, x_q[idx_q]} + 10'(spd_q[idx_q]);
  assign off = (nx >= 10'(X_LIMIT));

  // strictly greater keeps the lowest index among equal rows
  assign better = act_q[idx_q] && (ch_q[idx_q] == skey_q)
                  && (!bfound_q || x_q[idx_q] > bx_q);

  assign fc_wrap = (fc_q == FCW'(SPAWN_FRAMES - 1));

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    score_d  = score_q;
    misses_d = misses_q;
    if (inc_score && score_q != 16'hFFFF)
      score_d = score_q + 16'd1;
    if (inc_miss && misses_q != 8'hFF)
      misses_d = misses_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q        <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        ch_q[i]  <= '0;
        spd_q[i] <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
      idx_q        <= '0;
      fc_q         <= '0;
      frame_pend_q <= 1'b0;
      key_pend_q   <= 1'b0;
      key_q        <= '0;
      skey_q       <= '0;
      bfound_q     <= 1'b0;
      bidx_q       <= '0;
      bx_q         <= '0;
      hit_q        <= 1'b0;
      wrong_q      <= 1'b0;
      miss_q       <= 1'b0;
      score_q      <= '0;
      misses_q     <= '0;
    end else begin
      hit_q    <= 1'b0;
      wrong_q  <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= score_d;
      misses_q <= misses_d;
      // a new event in the dispatch cycle stays pending
      frame_pend_q <= frame_tick
                      | (frame_pend_q & ~start_frame);
      key_pend_q   <= key_valid
                      | (key_pend_q & ~start_key);
      if (key_valid) key_q <= key_code;

      unique case (state_q)
        S_IDLE: begin
          if (start_frame) begin
            idx_q <= '0;
          end else if (start_key) begin
            idx_q    <= '0;
            bfound_q <= 1'b0;
            // private copy: a key arriving mid-scan must not alter it
            skey_q   <= key_q;
          end
        end
        S_MOVE: begin
          if (act_q[idx_q]) begin
            if (off) begin
              act_q[idx_q] <= 1'b0;
              miss_q       <= 1'b1;
            end else begin
              x_q[idx_q] <= nx[8:0];
            end
          end
          idx_q <= idx_q + IW'(1);
        end
        S_SPAWN: begin
          if (fc_wrap) begin
            fc_q <= '0;
            if (free_found) begin
              act_q[free_idx] <= 1'b1;
              ch_q[free_idx]  <= gen_ch;
              spd_q[free_idx] <= (gen_speed == 4'd0) ?
                                 4'd1 : gen_speed;
              x_q[free_idx]   <= gen_x;
              y_q[free_idx]   <= gen_y;
            end
          end else begin
            fc_q <= fc_q + FCW'(1);
          end
        end
        S_SCAN: begin
          if (better) begin
            bfound_q <= 1'b1;
            bidx_q   <= idx_q;
            bx_q     <= x_q[idx_q];
          end
          idx_q <= idx_q + IW'(1);
        end
        S_KILL: begin
          if (bfound_q) begin
            act_q[bidx_q] <= 1'b0;
            hit_q         <= 1'b1;
          end else begin
            wrong_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_active = act_q[rd_idx];
  assign rd_ch     = ch_q[rd_idx];
  assign rd_x      = x_q[rd_idx];
  assign rd_y      = y_q[rd_idx];
  assign hit       = hit_q;
  assign wrong     = wrong_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign misses    = misses_q;

endmodule

// File: tb/tb_falling_letter_pool.sv
// tb_falling_letter_pool: directed and random checks of falling_letter_pool
// against a frame/keystroke-level reference model.
`timescale 1ns/1ps
module tb_falling_letter_pool;
  localparam int NS = 8;
  localparam int SF = 2;
  localparam int XL = 480;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] gen_ch = '0;
  logic [3:0] gen_speed = '0;
  logic [8:0] gen_x = '0;
  logic [9:0] gen_y = '0;
  logic [7:0] key_code = '0;
  logic [2:0] rd_idx = '0;
  logic       rd_active;
  logic [7:0] rd_ch;
  logic [8:0] rd_x;
  logic [9:0] rd_y;
  logic       busy, hit, wrong, miss;
  logic [15:0] score;
  logic [7:0]  misses;

  int errors = 0;
  int checks = 0;

  bit m_act [NS];
  int m_ch [NS];
  int m_spd [NS];
  int m_x [NS];
  int m_y [NS];
  int m_fc, m_score, m_misses;

  falling_letter_pool #(
    .NSLOT(NS), .SPAWN_FRAMES(SF), .X_LIMIT(XL)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .gen_ch(gen_ch), .gen_speed(gen_speed),
    .gen_x(gen_x), .gen_y(gen_y),
    .key_valid(key_valid), .key_code(key_code),
    .rd_idx(rd_idx), .rd_active(rd_active),
    .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .busy(busy), .hit(hit), .wrong(wrong),
    .miss(miss), .score(score), .misses(misses)
  );

  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_ch[i] = 0; m_spd[i] = 0;
      m_x[i] = 0; m_y[i] = 0;
    end
    m_fc = 0; m_score = 0; m_misses = 0;
  endfunction

  // one whole frame: move every letter, then a spawn attempt
  function automatic bit [NS-1:0] m_frame();
    bit [NS-1:0] lost = '0;
    bit placed = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        if (m_x[i] + m_spd[i] >= XL) begin
          m_act[i] = 0;
          lost[i] = 1;
          if (m_misses < 255) m_misses++;
        end else begin
          m_x[i] = m_x[i] + m_spd[i];
        end
      end
    end
    if (m_fc == SF - 1) begin
      m_fc = 0;
      for (int i = 0; i < NS; i++) begin
        if (!placed && !m_act[i]) begin
          placed = 1;
          m_act[i] = 1;
          m_ch[i] = int'(gen_ch);
          m_spd[i] = (gen_speed == 0) ? 1 : int'(gen_speed);
          m_x[i] = int'(gen_x);
          m_y[i] = int'(gen_y);
        end
      end
    end else begin
      m_fc++;
    end
    return lost;
  endfunction

  // lowest letter (largest row) wins, first index on ties
  function automatic int m_key(input int k);
    int best = -1;
    for (int i = 0; i < NS; i++)
      if (m_act[i] && m_ch[i] == k &&
          (best < 0 || m_x[i] > m_x[best]))
        best = i;
    if (best >= 0) begin
      m_act[best] = 0;
      if (m_score < 65535) m_score++;
    end
    return best;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    key_valid = 1'b0;
    step();
    rst = 1'b0;
    m_reset();
  endtask

  task automatic check_slots(input bit full, input string tag);
    for (int i = 0; i < NS; i++) begin
      rd_idx = 3'(i);
      #1;
      checks++;
      if (rd_active !== m_act[i]) begin
        errors++;
        $display("FAIL %s slot%0d active: got %b want %b",
                 tag, i, rd_active, m_act[i]);
      end else if (full || m_act[i]) begin
        checks++;
        if (rd_ch !== 8'(m_ch[i]) || rd_x !== 9'(m_x[i]) ||
            rd_y !== 10'(m_y[i])) begin
          errors++;
          $display("FAIL %s slot%0d fields: got ch=%h x=%0d y=%0d want ch=%h x=%0d y=%0d",
                   tag, i, rd_ch, rd_x, rd_y, m_ch[i], m_x[i], m_y[i]);
        end
      end
    end
  endtask

  // frame and/or key event; key is raised kat cycles after the tick
  task automatic run_event(input bit fr, input bit ky, input int kat,
                           input logic [7:0] k, input string tag);
    bit [NS-1:0] exp_mask, got_mask;
    int exp_res, nres, nend, hit_n, wrong_n;
    bit stray, busy_bad, exp_busy;
    exp_mask = '0;
    exp_res = -1;
    if (fr) exp_mask = m_frame();
    if (ky) exp_res = m_key(int'(k));
    nres = (fr && ky) ? 21 : 11;
    nend = nres + 2;
    got_mask = '0; stray = 0; busy_bad = 0;
    hit_n = 0; wrong_n = 0;
    key_code = k;
    frame_tick = fr;
    key_valid = ky && (kat == 0);
    for (int n = 1; n <= nend; n++) begin
      step();
      frame_tick = 1'b0;
      key_valid = ky && fr && (n == kat);
      if (miss === 1'b1) begin
        if (fr && n >= 3 && n < 3 + NS) got_mask[n-3] = 1'b1;
        else stray = 1;
      end else if (miss !== 1'b0) stray = 1;
      if (hit === 1'b1) begin
        hit_n++;
        if (!ky || n != nres) stray = 1;
      end
      if (wrong === 1'b1) begin
        wrong_n++;
        if (!ky || n != nres) stray = 1;
      end
      exp_busy = (n >= 2 && n <= 10) ||
                 (fr && ky && n >= 12 && n <= 20);
      if (busy !== exp_busy) busy_bad = 1;
    end
    checks++;
    if (got_mask !== exp_mask || stray) begin
      errors++;
      $display("FAIL %s pulses: miss got %b want %b stray=%0d",
               tag, got_mask, exp_mask, stray);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy: window got wrong, want high n=2..10%s",
               tag, (fr && ky) ? " and 12..20" : "");
    end
    if (ky) begin
      checks++;
      if (hit_n != (exp_res >= 0 ? 1 : 0) ||
          wrong_n != (exp_res < 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL %s key result: got hit=%0d wrong=%0d want match=%0d",
                 tag, hit_n, wrong_n, exp_res);
      end
    end
    checks++;
    if (score !== 16'(m_score) || misses !== 8'(m_misses)) begin
      errors++;
      $display("FAIL %s counters: got score=%0d misses=%0d want %0d %0d",
               tag, score, misses, m_score, m_misses);
    end
    check_slots(0, tag);
  endtask

  task automatic set_gen(input logic [7:0] c, input logic [3:0] s,
                         input logic [8:0] x, input logic [9:0] y);
    gen_ch = c; gen_speed = s; gen_x = x; gen_y = y;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_reset();
    checks++;
    if (busy !== 1'b0 || hit !== 1'b0 || wrong !== 1'b0 ||
        miss !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got busy=%b hit=%b wrong=%b miss=%b want 0",
               busy, hit, wrong, miss);
    end
    checks++;
    if (score !== 16'd0 || misses !== 8'd0) begin
      errors++;
      $display("FAIL reset counters: got %0d %0d want 0 0",
               score, misses);
    end
    check_slots(1, "reset");
  endtask

  task automatic test_spawn();
    apply_reset();
    set_gen(8'h41, 4'd3, 9'd0, 10'd100);
    run_event(1, 0, 0, 8'h00, "spawn_f1");
    run_event(1, 0, 0, 8'h00, "spawn_f2");
    rd_idx = 3'd0;
    #1;
    checks++;
    if (rd_active !== 1'b1 || rd_ch !== 8'h41 || rd_x !== 9'd0 ||
        rd_y !== 10'd100) begin
      errors++;
      $display("FAIL spawn slot0: got a=%b ch=%h x=%0d y=%0d want 1 41 0 100",
               rd_active, rd_ch, rd_x, rd_y);
    end
    run_event(1, 0, 0, 8'h00, "spawn_f3");
    rd_idx = 3'd0;
    #1;
    checks++;
    if (rd_x !== 9'd3) begin
      errors++;
      $display("FAIL spawn move: got x=%0d want 3", rd_x);
    end
  endtask

  task automatic test_bottom();
    apply_reset();
    set_gen(8'h4D, 4'd5, 9'd478, 10'd50);
    run_event(1, 0, 0, 8'h00, "bottom_f1");
    run_event(1, 0, 0, 8'h00, "bottom_f2");
    run_event(1, 0, 0, 8'h00, "bottom_exit");
    rd_idx = 3'd0;
    #1;
    checks++;
    if (misses !== 8'd1 || rd_active !== 1'b0) begin
      errors++;
      $display("FAIL bottom: got misses=%0d active=%b want 1 0",
               misses, rd_active);
    end
  endtask

  // slots 0..5 filled at speed 1; slot2 ends at x2+6, slot5 at x5
  task automatic fill6(input logic [8:0] x2, input logic [8:0] x5);
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      set_gen((k == 2 || k == 5) ? 8'h42 : 8'(8'h30 + k), 4'd1,
              (k == 2) ? x2 : ((k == 5) ? x5 : 9'd10),
              10'(k * 10));
      run_event(1, 0, 0, 8'h00, "fill_a");
      run_event(1, 0, 0, 8'h00, "fill_b");
    end
  endtask

  task automatic test_hit_priority();
    fill6(9'd94, 9'd200);
    run_event(0, 1, 0, 8'h42, "hit_deeper");
    rd_idx = 3'd5;
    #1;
    checks++;
    if (rd_active !== 1'b0 || score !== 16'd1) begin
      errors++;
      $display("FAIL hit_deeper: got slot5 a=%b score=%0d want 0 1",
               rd_active, score);
    end
    fill6(9'd194, 9'd200);
    run_event(0, 1, 0, 8'h42, "hit_tie");
    rd_idx = 3'd2;
    #1;
    checks++;
    if (rd_active !== 1'b0) begin
      errors++;
      $display("FAIL hit_tie: got slot2 a=%b want 0", rd_active);
    end
    rd_idx = 3'd5;
    #1;
    checks++;
    if (rd_active !== 1'b1) begin
      errors++;
      $display("FAIL hit_tie: got slot5 a=%b want 1", rd_active);
    end
  endtask

  task automatic test_wrong();
    int s0;
    s0 = int'(score);
    run_event(0, 1, 0, 8'h5A, "wrong_key");
    checks++;
    if (score !== 16'(s0)) begin
      errors++;
      $display("FAIL wrong_key score: got %0d want %0d", score, s0);
    end
  endtask

  task automatic test_collisions();
    apply_reset();
    set_gen(8'h51, 4'd5, 9'd478, 10'd7);
    run_event(1, 0, 0, 8'h00, "col_f1");
    run_event(1, 0, 0, 8'h00, "col_f2");
    run_event(1, 1, 4, 8'h51, "key_in_move");
    run_event(1, 0, 0, 8'h00, "col_f4");
    run_event(1, 1, 0, 8'h51, "tick_and_key");
    checks++;
    if (misses !== 8'd2 || score !== 16'd0) begin
      errors++;
      $display("FAIL collisions: got misses=%0d score=%0d want 2 0",
               misses, score);
    end
    apply_reset();
    for (int k = 0; k < NS; k++) begin
      set_gen(8'(8'h60 + k), 4'd1, 9'd0, 10'(k));
      run_event(1, 0, 0, 8'h00, "full_a");
      run_event(1, 0, 0, 8'h00, "full_b");
    end
    set_gen(8'h7F, 4'd2, 9'd5, 10'd9);
    run_event(1, 0, 0, 8'h00, "full_c");
    run_event(1, 0, 0, 8'h00, "full_drop");
    run_event(0, 1, 0, 8'h63, "full_kill3");
    run_event(1, 0, 0, 8'h00, "fc_reset");
    rd_idx = 3'd3;
    #1;
    checks++;
    if (rd_active !== 1'b0) begin
      errors++;
      $display("FAIL fc_reset: got slot3 a=%b want 0", rd_active);
    end
    run_event(1, 0, 0, 8'h00, "respawn");
    rd_idx = 3'd3;
    #1;
    checks++;
    if (rd_active !== 1'b1 || rd_ch !== 8'h7F) begin
      errors++;
      $display("FAIL respawn: got a=%b ch=%h want 1 7f",
               rd_active, rd_ch);
    end
  endtask

  task automatic test_reset_in_scan();
    bit pulsed = 0;
    apply_reset();
    set_gen(8'h52, 4'd1, 9'd0, 10'd3);
    run_event(1, 0, 0, 8'h00, "rs_f1");
    run_event(1, 0, 0, 8'h00, "rs_f2");
    key_code = 8'h52;
    key_valid = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      key_valid = 1'b0;
      if (hit !== 1'b0 || wrong !== 1'b0) pulsed = 1;
      if (n == 4) rst = 1'b1;
      if (n == 5) begin
        rst = 1'b0;
        m_reset();
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_in_scan busy: got %b want 0", busy);
        end
        check_slots(1, "reset_in_scan");
      end
    end
    checks++;
    if (pulsed || score !== 16'd0) begin
      errors++;
      $display("FAIL reset_in_scan pulses: got pulse=%0d score=%0d want 0 0",
               pulsed, score);
    end
  endtask

  task automatic test_score_sat();
    apply_reset();
    set_gen(8'h53, 4'd1, 9'd0, 10'd1);
    for (int k = 0; k < 4; k++)
      run_event(1, 0, 0, 8'h00, "ss_fill");
    force dut.score_q = 16'hFFFE;
    step();
    release dut.score_q;
    m_score = 65534;
    run_event(0, 1, 0, 8'h53, "score_to_max");
    run_event(0, 1, 0, 8'h53, "score_sat");
    checks++;
    if (score !== 16'hFFFF) begin
      errors++;
      $display("FAIL score_sat: got %h want ffff", score);
    end
  endtask

  task automatic test_miss_sat();
    apply_reset();
    set_gen(8'h4E, 4'd15, 9'd479, 10'd0);
    for (int k = 0; k < 514; k++)
      run_event(1, 0, 0, 8'h00, "miss_sat");
    checks++;
    if (misses !== 8'hFF) begin
      errors++;
      $display("FAIL miss_sat: got %h want ff", misses);
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int e = 0; e < 80; e++) begin
      set_gen(8'(8'h41 + $urandom_range(0, 3)),
              4'($urandom_range(0, 15)),
              9'($urandom_range(0, 400)),
              10'($urandom_range(0, 639)));
      r = $urandom_range(0, 3);
      if (r < 2)
        run_event(1, 0, 0, 8'h00, "rand_frame");
      else if (r == 2)
        run_event(0, 1, 0, 8'(8'h41 + $urandom_range(0, 4)),
                  "rand_key");
      else
        run_event(1, 1, $urandom_range(0, 9),
                  8'(8'h41 + $urandom_range(0, 4)), "rand_both");
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_spawn();
    test_bottom();
    test_hit_priority();
    test_wrong();
    test_collisions();
    test_reset_in_scan();
    test_score_sat();
    test_random();
    test_miss_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/falling_letter_pool.md
# falling_letter_pool

Slot manager directly downstream of the letter generator in the falling-letters typing game. It samples the generator's `ch`/`speed`/`x`/`y` outputs on a spawn schedule and holds up to NSLOT live letters. Once per frame it advances each letter's row, retires letters that reach the bottom as misses, and removes the lowest matching letter on each keystroke as a hit. A combinational read port lets the VGA renderer fetch any slot.

## Interface
- NSLOT, 8: number of letter slots. The scan index is 3 bits wide.
- SPAWN_FRAMES, 30: frames between spawn attempts. Must be ≥1.
- X_LIMIT, 480: first row that counts as "off screen". Rows 0..479 are visible.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- gen_ch  in  8  letter code from the generator.
- gen_speed  in  4  rows per frame from the generator. A value of 0 is stored as 1.
- gen_x  in  9  start row from the generator (normally 0).
- gen_y  in  10  column from the generator, 0..639.
- key_valid  in  1  one-cycle pulse when a key code is available.
- key_code  in  8  code of the pressed key.
- rd_idx  in  3  slot selected for the read port.
- rd_active, rd_ch, rd_x, rd_y  out  1/8/9/10  combinational contents of slot rd_idx.
- busy  out  1  high while the FSM is not in IDLE.
- hit  out  1  one-cycle registered pulse on a successful match.
- wrong  out  1  one-cycle registered pulse when a keystroke matches no slot.
- miss  out  1  one-cycle registered pulse for each letter that reaches X_LIMIT.
- score  out  16  hit count, saturating at 16'hFFFF.
- misses  out  8  miss count, saturating at 8'hFF.

## Operation
- Per-slot state: active (1 bit), ch (8), speed (4), x (9), y (10).
- Pending flags: frame_pend is set by frame_tick. key_pend and key_reg are set by key_valid. Each is one deep.
  - A second event of the same kind while its flag is set: the later key code overwrites key_reg, and a repeat frame is merged into the pending one.
- States:
  - IDLE: if frame_pend, clear it, set idx=0 and go to MOVE. Otherwise, if key_pend, clear it, set idx=0, clear the best-match register and go to SCAN. Frame has priority over key.
  - MOVE: process slot idx, one slot per cycle.
    - If the slot is active, compute nx = x + speed in 10 bits.
    - If nx ≥ X_LIMIT: clear active, pulse miss, increment misses. Otherwise x ← nx.
    - Increment idx. After slot NSLOT-1, go to SPAWN.
  - SPAWN: update the frame counter fc (0..SPAWN_FRAMES-1).
    - If fc == SPAWN_FRAMES-1: set fc ← 0 and load gen_* into the lowest-index inactive slot, setting active=1. If all slots are active, drop the spawn.
    - Otherwise fc ← fc+1.
    - Always return to IDLE.
  - SCAN: examine slot idx, one per cycle, for active && ch == key_reg.
    - Keep the match with the largest x. On equal x, keep the lowest index: a later slot replaces the best match only if its x is strictly greater.
    - After slot NSLOT-1, go to KILL.
  - KILL: if a match was found, clear that slot, pulse hit and increment score. Otherwise pulse wrong. Return to IDLE.
- Slots changed in the same cycle as a read are seen through rd_* from the following cycle.
- Generator outputs are sampled only in the SPAWN cycle and are not otherwise qualified.

## Timing
- Reset (synchronous): all slots inactive, slot fields 0, fc=0, flags clear, FSM in IDLE.
  - Outputs: busy=0, hit=wrong=miss=0, score=0, misses=0.
  - rd_* show slot contents, so they read 0 after reset.
- rst asserted in any state aborts the operation the next edge. A partial MOVE or SCAN leaves no residue, and pulses are suppressed.
- Frame processing, with frame_tick in cycle T while IDLE:
  - frame_pend is set at the end of T.
  - The FSM dispatches in T+1 and is in MOVE for T+2..T+2+NSLOT-1.
  - SPAWN is in T+2+NSLOT and the FSM is back in IDLE at T+3+NSLOT (11 cycles after the tick for NSLOT=8).
  - The miss pulse for slot i is high in cycle T+3+i.
- Keystroke, with key_valid in cycle K and the FSM IDLE with no frame pending:
  - SCAN runs for K+2..K+9 and KILL is in K+10.
  - hit or wrong is high in K+11, and score updates in the same cycle.
- busy is high in every non-IDLE cycle.
- Counters saturate and never wrap.
- x never wraps, because nx is computed in 10 bits.

## Test plan
- Spawn cadence: reset, SPAWN_FRAMES=2, gen_ch=8'h41, gen_speed=3, gen_x=0, gen_y=100, 2 frame ticks → slot0 becomes active with ch=41, x=0, y=100. After one more tick, x=3.
- Bottom exit: slot with x=478, speed=5, one tick → miss pulse exactly once, misses=1, slot inactive.
- Hit priority: slots 2 and 5 both hold 8'h42, with x=100 and x=200 → key 8'h42 clears slot 5 and gives hit, score=1. Equal x instead → slot 2 is cleared.
- Wrong key: key 8'h5A with no matching slot → wrong pulse, score unchanged, no slot changed.
- Collisions: key_valid during MOVE → key is processed after SPAWN. frame_tick and key_valid in the same IDLE cycle → frame is handled first, then key. All slots full at spawn → spawn dropped, fc still resets.
- Reset and saturation: rst during SCAN → no hit or wrong pulse, all slots cleared next cycle. Preload score=16'hFFFF, then a hit → score stays FFFF.
